// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
//   Configuration and update-handshake bundle between the AXI register slice
//   (master) and the seven-segment scan controller (slave).
//
//   Signals
//     disp_en      master->slave  global display enable (level)
//     digit_data   master->slave  hex nibble per digit, digit 0 in [3:0]
//     dp_mask      master->slave  decimal point on, per digit
//     en_mask      master->slave  digit visible, per digit
//     bright       master->slave  brightness level 0..15
//     upd_req      master->slave  one-cycle request to shadow-load the config
//     upd_ack      slave->master  one-cycle pulse: shadow load performed
//     upd_pending  slave->master  request accepted, load not yet performed
//     frame_done   slave->master  one-cycle pulse at the end of each frame
//
//   Handshake: upd_req is a single-cycle strobe and needs no back-pressure;
//   the slave records it in upd_pending and performs the load at the next
//   frame boundary (or immediately while the display is off). The cycle the
//   shadows take the live config values, upd_ack pulses for exactly one cycle
//   and upd_pending clears. Extra requests before that point merge into the
//   same load, which always samples the config values of the load cycle.
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                      disp_en;
  logic [4*NUM_DIGITS-1:0]   digit_data;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [NUM_DIGITS-1:0]     en_mask;
  logic [3:0]                bright;
  logic                      upd_req;
  logic                      upd_ack;
  logic                      upd_pending;
  logic                      frame_done;

  modport master (
    output disp_en, digit_data, dp_mask, en_mask, bright, upd_req,
    input  upd_ack, upd_pending, frame_done
  );

  modport slave (
    input  disp_en, digit_data, dp_mask, en_mask, bright, upd_req,
    output upd_ack, upd_pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit seven-segment display.
//   Each digit owns a slot of SCAN_DIV cycles: DEAD blanking cycles, then an
//   on-window whose length follows the shadowed brightness, then a blank tail.
//   Configuration is shadow-loaded only at frame boundaries (or while off), so
//   a frame is always drawn from one consistent set of values.
//
//   Ports
//     s00_axi_aclk     clock
//     s00_axi_aresetn  asynchronous active-low reset
//     cfg              seg_scan_ctrl_if slave: config inputs + update handshake
//     an               anode drive, one-hot active (polarity AN_ACTIVE_LOW)
//     seg              segments {g,f,e,d,c,b,a} (polarity SEG_ACTIVE_LOW)
//     dp               decimal point (polarity SEG_ACTIVE_LOW)
//     dbg_state        current scan state (0 OFF, 1 DEAD, 2 ON, 3 TAIL)
//
//   All outputs are registered: the pins in cycle t+1 reflect the state the
//   scanner was in during cycle t.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEAD           = 50,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  seg_scan_ctrl_if.slave        cfg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [1:0]            dbg_state
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  // Product width for W*(bright+1): W < 2^CW and (bright+1) <= 16.
  localparam int unsigned PW = CW + 5;
  localparam int unsigned W  = SCAN_DIV - DEAD;

  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  // XOR masks that turn active-high internal values into pin levels.
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_INV  = SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [3:0]              sh_bright_q, sh_bright_d;

  logic                    upd_pending_q, upd_pending_d;
  logic                    upd_ack_q, upd_ack_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  // ---------------------------------------------------------------------------
  // Segment decoder, active-high {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // PWM window: on_len = (W*(sh_bright+1))>>4, so bright=15 fills the whole
  // non-blanked part of the slot and bright=0 may round down to zero.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] on_prod;
  logic [CW:0]   on_len;
  logic [CW:0]   on_last;
  logic          on_zero;
  logic          on_end;

  always_comb begin
    on_prod = PW'(W) * (PW'(sh_bright_q) + PW'(1));
    on_len  = on_prod[PW-1:4];
    on_zero = (on_len == '0);
    on_last = on_len + (CW+1)'(DEAD) - (CW+1)'(1);
    on_end  = ({1'b0, cnt_q} == on_last);
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state, slot counter, digit index, frame pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;

    if (!cfg.disp_en) begin
      // Disable wins over everything, including a slot end: no frame pulse.
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == ST_OFF) begin
      state_d = ST_DEAD;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (cnt_q == SLOT_LAST) begin
      // Slot end takes priority over the on-window end, which can coincide
      // with it at full brightness.
      state_d = ST_DEAD;
      cnt_d   = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      case (state_q)
        ST_DEAD: begin
          // A zero-length window skips ON entirely.
          if (cnt_q == DEAD_LAST) state_d = on_zero ? ST_TAIL : ST_ON;
        end
        ST_ON: begin
          if (on_end) state_d = ST_TAIL;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow load / update handshake
  // ---------------------------------------------------------------------------
  logic load_point;
  logic do_load;

  always_comb begin
    load_point    = frame_done_d | (state_q == ST_OFF);
    // A request arriving in the load cycle itself is served immediately.
    do_load       = load_point & (upd_pending_q | cfg.upd_req);

    sh_data_d     = sh_data_q;
    sh_dp_d       = sh_dp_q;
    sh_en_d       = sh_en_q;
    sh_bright_d   = sh_bright_q;
    upd_ack_d     = do_load;
    upd_pending_d = upd_pending_q | cfg.upd_req;

    if (do_load) begin
      sh_data_d     = cfg.digit_data;
      sh_dp_d       = cfg.dp_mask;
      sh_en_d       = cfg.en_mask;
      sh_bright_d   = cfg.bright;
      upd_pending_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin drive, decided from the current state and registered
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;
  logic                  lit;

  always_comb begin
    an_hi  = '0;
    seg_hi = '0;
    dp_hi  = 1'b0;
    // Gating with disp_en blanks the pins in the same cycle the FSM drops to OFF.
    lit    = cfg.disp_en && (state_q == ST_ON);

    if (lit) begin
      // Segments follow the digit even when its anode is masked off.
      an_hi[idx_q] = sh_en_q[idx_q];
      seg_hi       = seg_decode(sh_data_q[{idx_q, 2'b00} +: 4]);
      dp_hi        = sh_dp_q[idx_q];
    end

    an_d  = an_hi ^ AN_INV;
    seg_d = seg_hi ^ SEG_INV;
    dp_d  = dp_hi ^ DP_INV;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q       <= ST_OFF;
      cnt_q         <= '0;
      idx_q         <= '0;
      sh_data_q     <= '0;
      sh_dp_q       <= '0;
      sh_en_q       <= '0;
      sh_bright_q   <= '0;
      upd_pending_q <= 1'b0;
      upd_ack_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      an_q          <= AN_INV;
      seg_q         <= SEG_INV;
      dp_q          <= DP_INV;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sh_data_q     <= sh_data_d;
      sh_dp_q       <= sh_dp_d;
      sh_en_q       <= sh_en_d;
      sh_bright_q   <= sh_bright_d;
      upd_pending_q <= upd_pending_d;
      upd_ack_q     <= upd_ack_d;
      frame_done_q  <= frame_done_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign cfg.upd_ack     = upd_ack_q;
  assign cfg.upd_pending = upd_pending_q;
  assign cfg.frame_done  = frame_done_q;
  assign an              = an_q;
  assign seg             = seg_q;
  assign dp              = dp_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Bench for seg_scan_ctrl with NUM_DIGITS=8, SCAN_DIV=16, DEAD=2 and
//   active-low pins. For every frame the expected pin/handshake trace is
//   derived from the slot layout (2 blank cycles, on_len lit cycles, blank
//   tail) and queued; a monitor pops one entry per cycle and compares.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned SD = 16;
  localparam int unsigned DT = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [3:0]  bright;
  } cfg_t;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rst_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dbg_state;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) cfg_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS     (N),
    .SCAN_DIV       (SD),
    .DEAD           (DT),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .cfg             (cfg_if),
    .an              (an),
    .seg             (seg),
    .dp              (dp),
    .dbg_state       (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  // {upd_ack, frame_done, an[7:0], seg[6:0], dp}
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic cfg_t mk_cfg(input logic [31:0] d, input logic [7:0] p,
                                  input logic [7:0] e, input logic [3:0] b);
    cfg_t c;
    c.data = d; c.dp = p; c.en = e; c.bright = b;
    return c;
  endfunction

  // Expected outputs seen (slot i, cycle k) after a frame_done observation.
  function automatic logic [17:0] exp_entry(input cfg_t c, input int i, input int k,
                                            input logic ack_end);
    int         on_len;
    logic       lit;
    logic       last;
    logic [7:0] an_hi;
    logic [6:0] seg_hi;
    logic       dp_hi;
    logic [3:0] nib;
    on_len = ((SD - DT) * (int'(c.bright) + 1)) >> 4;
    lit    = (k >= DT) && (k < DT + on_len);
    last   = (i == N - 1) && (k == SD - 1);
    nib    = c.data[4*i +: 4];
    an_hi  = 8'h00;
    if (lit && c.en[i]) an_hi[i] = 1'b1;
    seg_hi = lit ? dec(nib) : 7'h00;
    dp_hi  = lit ? c.dp[i] : 1'b0;
    return {last ? ack_end : 1'b0, last, ~an_hi, ~seg_hi, ~dp_hi};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input cfg_t c);
    cfg_if.digit_data = c.data;
    cfg_if.dp_mask    = c.dp;
    cfg_if.en_mask    = c.en;
    cfg_if.bright     = c.bright;
  endtask

  task automatic pulse_req();
    cfg_if.upd_req = 1'b1;
    tick();
    cfg_if.upd_req = 1'b0;
  endtask

  // Wait for frame_done with a cycle budget; the cycle count is compared.
  task automatic wait_fd(input int expect_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cfg_if.frame_done && n < 400);
    check("fd_latency", n, expect_n);
  endtask

  // Starts at a cycle where frame_done is observed; checks the next frame.
  task automatic run_frame(input cfg_t c, input logic ack_end);
    logic [17:0] e;
    logic [17:0] o;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < SD; k++)
        exp_q.push_back(exp_entry(c, i, k, ack_end));
    for (int n = 0; n < N * SD; n++) begin
      tick();
      e = exp_q.pop_front();
      o = {cfg_if.upd_ack, cfg_if.frame_done, an, seg, dp};
      check($sformatf("pins[%0d]", n), 32'(o), 32'(e));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  cfg_t cfg_a, cfg_b, cfg_c, cfg_d, cfg_e1, cfg_e2, cfg_e3, cfg_f, cfg_g, cfg_z;

  initial begin
    cfg_a  = mk_cfg(32'h76543210, 8'h00, 8'hFF, 4'hF);
    cfg_b  = mk_cfg(32'hFFFFFFFF, 8'h00, 8'hFF, 4'h7);
    cfg_c  = mk_cfg(32'h89ABCDEF, 8'hFF, 8'hFF, 4'h0);
    cfg_d  = mk_cfg(32'h76543210, 8'h01, 8'h01, 4'hF);
    cfg_e1 = mk_cfg(32'h89ABCDEF, 8'hAA, 8'hFF, 4'hF);
    cfg_e2 = mk_cfg(32'h13579BDF, 8'h55, 8'hF0, 4'hB);
    cfg_e3 = mk_cfg(32'hDEADBEEF, 8'h0F, 8'h5A, 4'h3);
    cfg_f  = mk_cfg(32'h01234567, 8'h80, 8'hFF, 4'hF);
    cfg_g  = mk_cfg(32'h88888888, 8'hFF, 8'hFF, 4'hF);
    cfg_z  = mk_cfg(32'h0, 8'h0, 8'h0, 4'h0);

    rst_n          = 1'b0;
    cfg_if.disp_en = 1'b0;
    cfg_if.upd_req = 1'b0;
    apply_cfg(cfg_z);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_ack", 32'(cfg_if.upd_ack), 32'h0);
    check("rst_pend", 32'(cfg_if.upd_pending), 32'h0);
    check("rst_fd", 32'(cfg_if.frame_done), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: update while off is acknowledged one cycle later, pins stay blank
    apply_cfg(cfg_a);
    pulse_req();
    check("off_ack", 32'(cfg_if.upd_ack), 32'h1);
    check("off_pend", 32'(cfg_if.upd_pending), 32'h0);
    tick();
    check("off_ack_clr", 32'(cfg_if.upd_ack), 32'h0);
    check("off_an", 32'(an), 32'hFF);
    check("off_seg", 32'(seg), 32'h7F);

    // 2: enable; first frame ends 128 cycles after the first slot starts
    cfg_if.disp_en = 1'b1;
    wait_fd(N * SD + 1);
    check("fd_state", 32'(dbg_state), 32'h1);
    run_frame(cfg_a, 1'b0);

    // 3: mid-frame update held until the frame boundary
    fork
      run_frame(cfg_a, 1'b1);
      begin
        repeat (40) tick();
        apply_cfg(cfg_b);
        pulse_req();
        check("mid_pend", 32'(cfg_if.upd_pending), 32'h1);
        repeat (50) tick();
        check("mid_pend_hold", 32'(cfg_if.upd_pending), 32'h1);
      end
    join
    check("pend_clr", 32'(cfg_if.upd_pending), 32'h0);

    // 4: bright=0 blanks everything; then only digit 0 enabled
    fork
      run_frame(cfg_b, 1'b1);
      begin
        repeat (10) tick();
        apply_cfg(cfg_c);
        pulse_req();
      end
    join
    fork
      run_frame(cfg_c, 1'b1);
      begin
        repeat (10) tick();
        apply_cfg(cfg_d);
        pulse_req();
      end
    join

    // 5: two merged requests plus one in the frame_done cycle -> one ack,
    //    last values win; then a request only in the frame_done cycle
    fork
      run_frame(cfg_d, 1'b1);
      begin
        repeat (20) tick();
        apply_cfg(cfg_e1);
        pulse_req();
        check("merge_pend", 32'(cfg_if.upd_pending), 32'h1);
        repeat (39) tick();
        apply_cfg(cfg_e2);
        pulse_req();
        repeat (66) tick();
        apply_cfg(cfg_e3);
        pulse_req();
      end
    join
    fork
      run_frame(cfg_e3, 1'b1);
      begin
        repeat (N * SD - 1) tick();
        apply_cfg(cfg_f);
        pulse_req();
      end
    join
    run_frame(cfg_f, 1'b0);

    // 6: reset mid-ON with a pending request
    repeat (3) tick();
    apply_cfg(cfg_g);
    pulse_req();
    check("pre_rst_pend", 32'(cfg_if.upd_pending), 32'h1);
    check("pre_rst_an", 32'(an), 32'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hFF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'h1);
    check("arst_pend", 32'(cfg_if.upd_pending), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_fd(N * SD + 1);
    check("post_rst_pend", 32'(cfg_if.upd_pending), 32'h0);
    run_frame(cfg_z, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the seven-segment display inside the seg-show AXI4-Lite IP.
- Takes digit values, decimal-point mask, digit-enable mask and brightness from the AXI register slice. Values are shadow-loaded only at frame boundaries via a req/ack handshake.
- Drives anode and segment pins, with dead-time between digits and per-slot PWM dimming.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits; 2..8.
- SCAN_DIV, 100000: clock cycles per digit slot; must be at least DEAD+16.
- DEAD, 50: blanking cycles at the start of each slot, for anti-ghosting.
- SEG_ACTIVE_LOW, 1: 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 1: 1 inverts an at the pins.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- disp_en  in  1  global display enable (level).
- digit_data  in  4*NUM_DIGITS  hex nibble per digit; digit 0 = bits [3:0].
- dp_mask  in  NUM_DIGITS  decimal point on, per digit.
- en_mask  in  NUM_DIGITS  digit visible, per digit.
- bright  in  4  brightness level 0..15.
- upd_req  in  1  one-cycle pulse: request shadow load of the four config inputs.
- upd_ack  out  1  one-cycle pulse: shadow load performed.
- upd_pending  out  1  request accepted, load not yet performed.
- frame_done  out  1  one-cycle pulse at the end of the last digit slot.
- an  out  NUM_DIGITS  anode drive, one-hot active.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State OFF; idx=0; cnt=0; all shadows 0; upd_pending=0; upd_ack=0; frame_done=0.
  - an, seg and dp all inactive at the pins (e.g. an=all 1s, seg=7'h7F, dp=1 with active-low defaults).
- All outputs are registered. Decisions made in cycle t are visible at the pins in cycle t+1.
- Slot timing: cnt counts 0..SCAN_DIV-1 per slot.
  - W = SCAN_DIV-DEAD.
  - on_len = (W*(sh_bright+1))>>4, computed from the shadow value.
  - bright=15 gives on_len=W.
- FSM states:
  - OFF: all pins inactive; cnt and idx held at 0. disp_en=1 moves to DEAD with idx=0, cnt=0.
  - DEAD (cnt<DEAD): all pins inactive. When cnt=DEAD-1, move to ON.
  - ON (DEAD<=cnt<DEAD+on_len): an[idx] active only if sh_en[idx]=1; seg=decode(sh_data[idx]); dp=sh_dp[idx]. Move to TAIL when cnt=DEAD+on_len-1, or at slot end.
  - TAIL: all pins inactive until slot end.
  - Slot end (cnt=SCAN_DIV-1): cnt<=0, state DEAD, idx<=idx+1. At idx=NUM_DIGITS-1, idx wraps to 0 and frame_done pulses.
  - disp_en=0 in any state: move to OFF the next cycle; pins inactive; no frame_done.
- Disabled digit (sh_en=0): its slot is still consumed, so the refresh period stays constant; its anode stays inactive.
- Decoder (active-high, gfedcba), entries 0..F:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Update handshake:
  - upd_req sets upd_pending.
  - Load point: the cycle frame_done is generated, or any cycle in state OFF.
  - At the load point with pending (or upd_req in that same cycle): all shadows <= live inputs of that cycle; upd_ack=1 for one cycle; upd_pending=0.
  - Repeated upd_req while pending: merged, producing a single ack; the latest input values are loaded.
  - Shadows are never modified mid-frame.
- Reset mid-frame: immediate return to reset values; any pending request is dropped with no ack.

Test Plan (NUM_DIGITS=8, SCAN_DIV=16, DEAD=2, active-low pins):
1. Reset, then disp_en=0 and upd_req with digit_data=32'h76543210, en_mask=FF, bright=F.
   -> upd_ack 1 cycle later; pins stay an=FF, seg=7F.
2. Continue from 1, disp_en=1.
   -> Each 16-cycle slot shows 2 blank cycles, then 14 cycles with an=~(1<<idx) and seg=~decode(idx) (digit 0: seg=7'h40).
   -> frame_done every 128 cycles.
3. upd_req mid-frame with bright=7 and digit_data=32'hFFFFFFFF.
   -> Old values persist to the frame end; upd_pending=1 until then.
   -> upd_ack coincides with frame_done.
   -> Next frame: 7 lit cycles per slot, seg=~7'h71.
4. bright=0 -> on_len=0, so no anode ever active. en_mask=8'h01 -> only digit 0 lights; frame period stays 128 cycles.
5. Two upd_req pulses in one frame, plus one upd_req in the frame_done cycle.
   -> Exactly one upd_ack per load point; the last values are loaded.
6. Deassert aresetn mid-ON with upd_pending=1.
   -> Pins go inactive asynchronously; after release, upd_pending=0 with no ack; display stays blank until the next update.
